tiny16_uart_tx: RTL and testbench
=================================

// Module: tiny16_uart_tx
// PURPOSE
//  Serial output stage fed by the tiny16 core's 8-bit OUT port. Each write strobe pushes
//  one byte into a small FIFO. An 8N1 transmitter drains the FIFO onto TX, LSB first.
//  Lets programs stream bytes to a host over one pin without stalling on every character.
// PARAMETERS
//  CLKS_PER_BIT  139  CLK cycles per UART bit (16 MHz / 115200); legal range 2..65535
//  FIFO_DEPTH    4    FIFO entries; power of two, 2..16
// PORTS
//  CLK    in   1  system clock; all state updates on rising edge
//  RST    in   1  asynchronous, active-low reset
//  WE     in   1  write strobe from core; one-cycle pulse per byte
//  DATA   in   8  byte to transmit (core OUT bus), sampled when WE=1
//  FULL   out  1  FIFO holds FIFO_DEPTH entries
//  EMPTY  out  1  FIFO holds 0 entries
//  BUSY   out  1  FSM not in IDLE (frame in progress)
//  TX     out  1  serial line; idle high
// BEHAVIOUR
//  Reset (RST=0, any time, async): TX=1, BUSY=0, EMPTY=1, FULL=0.
//   FIFO pointers/count=0, FSM=IDLE, baud counter=0, bit index=0.
//   A frame in flight is abandoned; TX returns high immediately; queued bytes are discarded.
//  FIFO: registered pointers, width $clog2(FIFO_DEPTH); count has one extra bit.
//   Pointers wrap modulo FIFO_DEPTH.
//   Write accepted iff WE=1 and FULL=0 at the sampling edge.
//   WE while FULL=1 is dropped silently; FIFO contents unchanged. This holds even if a pop
//   occurs in the same cycle.
//   Pop occurs only from FSM IDLE when EMPTY=0. The same-cycle accepted write plus pop
//   leaves count unchanged.
//   FULL/EMPTY are registered and reflect count after the edge.
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE: TX=1. If EMPTY=0, latch head byte into the shift register, pop, go to START,
//    clear baud counter.
//   START: TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
//   DATA: TX=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit.
//    After bit 7, go to STOP.
//   STOP: TX=1 for CLKS_PER_BIT cycles, then go to IDLE.
//  Timing and latency
//   TX is a registered output.
//   A write at edge k into an empty, idle block: EMPTY=0 after edge k. The FSM pops at
//    edge k+1, and TX falls after edge k+1.
//   Frame = exactly 10*CLKS_PER_BIT cycles from TX fall to end of stop bit.
//   Back-to-back: with a byte queued, IDLE lasts exactly 1 cycle between frames.
//    Inter-frame gap is therefore 1 CLK of extra high time.
//   Baud counter counts 0..CLKS_PER_BIT-1 and wraps; no drift across frames.
//  BUSY=1 in START/DATA/STOP, 0 in IDLE. It is registered with the state.
//  DATA is sampled only on accepted writes; changes at other times have no effect.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1 Reset: hold RST=0 for 3 cycles -> TX=1, BUSY=0, EMPTY=1, FULL=0.
//  2 Single byte: WE pulse with DATA=8'hA5 -> TX falls 2 edges later.
//    TX sequence per 4 cycles: 0,1,0,1,0,0,1,0,1,1. BUSY high 40 cycles; EMPTY=1 after pop.
//  3 Overflow: 6 consecutive WE (8'h01..8'h06) while idle.
//    -> the first is popped at once and 4 are queued, so FULL=1 and 8'h06 is dropped.
//    Line carries 01,02,03,04,05 with 1-cycle gaps between frames.
//  4 Write while popping: FIFO full, WE on the IDLE pop cycle.
//    -> write dropped; count goes 4 to 3; FULL=0 next cycle.
//  5 Mid-frame reset: assert RST=0 during DATA bit 3 of 8'hFF.
//    -> TX=1 asynchronously, EMPTY=1. After release and a new write of 8'h3C,
//    a clean full frame is sent.
//  6 Pointer wrap: 10 bytes written one per frame end.
//    -> all 10 received in order; pointers wrap twice with no corruption.

Source files
------------

// File: rtl/tiny16_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tiny16_uart_tx
// Description : Byte FIFO feeding an 8N1 UART transmitter (LSB first, idle high).
// Revision    : 1.0 - initial release
// ============================================================================
module tiny16_uart_tx #(
    parameter int CLKS_PER_BIT = 139,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [7:0] data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       tx
);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);
    localparam logic [15:0]        c_baud_last = 16'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_next;
    logic               r_full;
    logic               r_empty;
    logic               w_push;
    logic               w_pop;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [15:0] r_baud;
    logic [15:0] w_baud_next;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic        w_baud_done;
    logic        r_tx;
    logic        w_tx_next;
    logic        r_busy;
    logic        w_busy_next;

    // A write is judged against the registered FULL, so a same-cycle pop cannot rescue it.
    assign w_push      = we & ~r_full;
    assign w_pop       = (r_state == c_idle) & ~r_empty;
    assign w_baud_done = (r_baud == c_baud_last);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_cnt_w'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_depth);
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud + 16'd1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        case (r_state)
            c_idle: begin
                w_baud_next = '0;
                w_bit_next  = '0;
                if (!r_empty) begin
                    w_state_next = c_start;
                    w_shift_next = r_mem[r_rd_ptr];
                end
            end
            c_start: begin
                if (w_baud_done) begin
                    w_state_next = c_data;
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                end
            end
            c_data: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_next = c_stop;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            c_stop: begin
                if (w_baud_done) begin
                    w_state_next = c_idle;
                    w_baud_next  = '0;
                end
            end
            default: begin
                w_state_next = c_idle;
            end
        endcase
    end

    // TX and BUSY are decoded from the next state so they register alongside it.
    always_comb begin
        w_busy_next = (w_state_next != c_idle);
        case (w_state_next)
            c_start: w_tx_next = 1'b0;
            c_data:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    assign full  = r_full;
    assign empty = r_empty;
    assign busy  = r_busy;
    assign tx    = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_tiny16_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_tiny16_uart_tx
// Description : Self-checking bench; a line monitor checks frames against a byte queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tiny16_uart_tx;
    localparam int CLKS_PER_BIT = 4;
    localparam int FIFO_DEPTH   = 4;
    localparam int FRAME        = 10 * CLKS_PER_BIT;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [7:0] data;
    logic       full;
    logic       empty;
    logic       busy;
    logic       tx;

    int         n_checks;
    int         n_errors;
    int         cyc;
    logic [7:0] exp_q[$];
    int         falls[$];
    logic       mon_active;

    tiny16_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .data (data),
        .full (full),
        .empty(empty),
        .busy (busy),
        .tx   (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Line monitor: each frame is checked cycle by cycle against the oldest queued byte.
    initial begin : monitor
        int         i;
        int         b;
        int         bad;
        logic       unexpected;
        logic       eb;
        logic [7:0] ex;
        logic [7:0] rx;
        mon_active = 1'b0;
        i = 0;
        bad = 0;
        unexpected = 1'b0;
        ex = '0;
        rx = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && tx === 1'b0) begin
                    falls.push_back(cyc);
                    mon_active = 1'b1;
                    i = 0;
                    bad = 0;
                    rx = '0;
                    unexpected = (exp_q.size() == 0);
                    ex = unexpected ? 8'h00 : exp_q.pop_front();
                end
                if (mon_active) begin
                    b = (i - CLKS_PER_BIT) / CLKS_PER_BIT;
                    if (i < CLKS_PER_BIT) eb = 1'b0;
                    else if (i >= 9 * CLKS_PER_BIT) eb = 1'b1;
                    else eb = ex[b[2:0]];
                    if (tx !== eb) bad++;
                    if (i >= CLKS_PER_BIT && i < 9 * CLKS_PER_BIT && (i % CLKS_PER_BIT) == CLKS_PER_BIT / 2)
                        rx[b[2:0]] = tx;
                    if (i == FRAME - 1) begin
                        n_checks++;
                        if (unexpected || bad != 0 || rx !== ex) begin
                            n_errors++;
                            $display("FAIL frame: got byte %02h (%0d bad cycles, unexpected=%0b), expected %02h",
                                     rx, bad, unexpected, ex);
                        end
                        mon_active = 1'b0;
                    end else begin
                        i++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

    task automatic write_byte(input logic [7:0] b);
        we   = 1'b1;
        data = b;
        @(negedge clk);
        we   = 1'b0;
        data = 8'h00;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_active || busy !== 1'b0 || empty !== 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 2000) begin
            n_errors++;
            $display("FAIL %s_drain: timed out with %0d bytes pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        we    = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) begin n_errors++; $display("FAIL reset_tx: got %b, expected 1", tx); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_checks++;
        if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b, expected 1", empty); end
        n_checks++;
        if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b, expected 0", full); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        int cnt;
        exp_q.push_back(8'hA5);
        write_byte(8'hA5);
        n_checks++;
        if (empty !== 1'b0 || tx !== 1'b1) begin
            n_errors++;
            $display("FAIL single_after_write: empty=%b tx=%b, expected empty=0 tx=1", empty, tx);
        end
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b0 || busy !== 1'b1 || empty !== 1'b1) begin
            n_errors++;
            $display("FAIL single_after_pop: tx=%b busy=%b empty=%b, expected 0 1 1", tx, busy, empty);
        end
        cnt = 1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            cnt++;
        end
        n_checks++;
        if (cnt != FRAME) begin
            n_errors++;
            $display("FAIL single_busy_len: got %0d cycles, expected %0d", cnt, FRAME);
        end
        wait_done("single");
    endtask

    task automatic test_overflow();
        falls.delete();
        for (int k = 1; k <= 6; k++) begin
            if (k <= 5) exp_q.push_back(8'(k));
            write_byte(8'(k));
        end
        n_checks++;
        if (full !== 1'b1) begin n_errors++; $display("FAIL overflow_full: got %b, expected 1", full); end
        wait_done("overflow");
        n_checks++;
        if (falls.size() != 5) begin
            n_errors++;
            $display("FAIL overflow_frames: got %0d frames, expected 5", falls.size());
        end else begin
            for (int k = 1; k < 5; k++) begin
                n_checks++;
                if (falls[k] - falls[k-1] != FRAME + 1) begin
                    n_errors++;
                    $display("FAIL overflow_gap%0d: got %0d cycles between falls, expected %0d",
                             k, falls[k] - falls[k-1], FRAME + 1);
                end
            end
        end
    endtask

    task automatic test_write_while_pop();
        int n;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(8'(8'h10 + k));
            write_byte(8'(8'h10 + k));
        end
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 100 || full !== 1'b1) begin
            n_errors++;
            $display("FAIL wwp_idle_full: waited %0d, full=%b, expected idle with full=1", n, full);
        end
        write_byte(8'h99);
        n_checks++;
        if (full !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL wwp_after_pop: full=%b busy=%b, expected full=0 busy=1", full, busy);
        end
        wait_done("wwp");
    endtask

    task automatic test_midframe_reset();
        int n;
        exp_q.push_back(8'hFF);
        write_byte(8'hFF);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (4 * CLKS_PER_BIT + 1) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_checks++;
        if (tx !== 1'b1 || empty !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_async: tx=%b empty=%b busy=%b full=%b, expected 1 1 0 0",
                     tx, empty, busy, full);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_release: tx=%b busy=%b, expected 1 0", tx, busy);
        end
        exp_q.push_back(8'h3C);
        write_byte(8'h3C);
        wait_done("midreset");
    endtask

    task automatic test_pointer_wrap();
        logic [7:0] b;
        int         n;
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            write_byte(b);
            n = 0;
            while (busy !== 1'b1 && n < 5) begin @(negedge clk); n++; end
            while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
            n_checks++;
            if (n >= 100) begin
                n_errors++;
                $display("FAIL wrap_frame%0d: frame did not finish in %0d cycles", k, n);
            end
        end
        wait_done("wrap");
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        we       = 1'b0;
        data     = 8'h00;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_overflow();
        test_write_while_pop();
        test_midframe_reset();
        test_pointer_wrap();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
